// File: rtl/in_rd_controller_mq_pkg.sv
// Shared constants for the multi-queue input read controller.
// State codes are kept as plain logic constants for legacy tooling.
package in_rd_controller_mq_pkg;

  localparam int NUM_Q_DEF        = 4;
  localparam int WIDTH_SEL_DEF    = 3;
  localparam int WIDTH_LENGTH_DEF = 6;
  localparam int WIDTH_Q_DEF      = 2;

  typedef logic [1:0] state_t;

  // Gray-style walk so adjacent states differ in one bit
  localparam state_t S_IDLE = 2'b00;
  localparam state_t S_HDR  = 2'b01;
  localparam state_t S_RD   = 2'b11;
  localparam state_t S_DONE = 2'b10;

endpackage

// File: rtl/in_rd_controller_mq_if.sv
// Queue-bank request side plus downstream beat handshake.
// master = controller, slave = queue bank / crossbar side.
interface in_rd_controller_mq_if #(
  parameter int NUM_Q        = 4,
  parameter int WIDTH_SEL    = 3,
  parameter int WIDTH_LENGTH = 6,
  parameter int WIDTH_Q      = 2
) ();

  logic [NUM_Q-1:0]              req;
  logic [NUM_Q*WIDTH_SEL-1:0]    req_rx;
  logic [NUM_Q*WIDTH_LENGTH-1:0] req_len;
  logic [NUM_Q-1:0]              req_ack;
  logic [NUM_Q-1:0]              fifo_empty;
  logic [NUM_Q-1:0]              fifo_rd_en;
  logic [WIDTH_Q-1:0]            q_sel;
  logic [WIDTH_SEL-1:0]          rx_out;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_sel;
  logic                          out_last;
  logic                          busy;

  modport master (
    input  req, req_rx, req_len, fifo_empty, out_ready,
    output req_ack, fifo_rd_en, q_sel, rx_out,
    output out_valid, out_sel, out_last, busy
  );

  modport slave (
    output req, req_rx, req_len, fifo_empty, out_ready,
    input  req_ack, fifo_rd_en, q_sel, rx_out,
    input  out_valid, out_sel, out_last, busy
  );

endinterface

// File: rtl/in_rd_controller_mq_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping.
// Produces a one-hot grant and its index; silent when en is low.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/in_rd_controller_mq.sv
// Multi-queue input read controller: rr grant, header beat,
// LEN+1 payload beats under valid/ready, FWFT pop per beat.
module in_rd_controller_mq
  import in_rd_controller_mq_pkg::*;
#(
  parameter int NUM_Q        = NUM_Q_DEF,
  parameter int WIDTH_SEL    = WIDTH_SEL_DEF,
  parameter int WIDTH_LENGTH = WIDTH_LENGTH_DEF,
  parameter int WIDTH_Q      = WIDTH_Q_DEF
) (
  input logic                clk,
  input logic                rst,
  in_rd_controller_mq_if.master bus
);

  state_t                  state;
  logic [WIDTH_Q-1:0]      rr_ptr;
  logic [WIDTH_Q-1:0]      q_reg;
  logic [WIDTH_SEL-1:0]    rx_reg;
  logic [WIDTH_LENGTH-1:0] len_reg;
  logic [WIDTH_LENGTH-1:0] cnt;

  logic [NUM_Q-1:0]        gnt;
  logic [WIDTH_Q-1:0]      gnt_idx;
  logic                    in_idle;
  logic                    in_hdr;
  logic                    in_rd;
  logic                    fire;
  logic                    at_last;

  assign in_idle = (state == S_IDLE);
  assign in_hdr  = (state == S_HDR);
  assign in_rd   = (state == S_RD);

  rr_arbiter #(.N(NUM_Q), .W(WIDTH_Q)) u_arb (
    .req (bus.req),
    .ptr (rr_ptr),
    .en  (in_idle),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign at_last = (cnt == len_reg);

  always_comb begin
    bus.out_valid  = in_hdr | (in_rd & ~bus.fifo_empty[q_reg]);
    fire           = bus.out_valid & bus.out_ready;
    bus.fifo_rd_en = '0;
    if (in_rd && fire)
      bus.fifo_rd_en[q_reg] = 1'b1;
  end

  assign bus.req_ack  = gnt;
  assign bus.q_sel    = q_reg;
  assign bus.rx_out   = rx_reg;
  assign bus.out_sel  = in_hdr;
  assign bus.out_last = in_rd & bus.out_valid & at_last;
  assign bus.busy     = ~in_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      q_reg   <= '0;
      rx_reg  <= '0;
      len_reg <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|bus.req) begin
            q_reg   <= gnt_idx;
            rx_reg  <= bus.req_rx[int'(gnt_idx)*WIDTH_SEL +: WIDTH_SEL];
            len_reg <= bus.req_len[int'(gnt_idx)*WIDTH_LENGTH +: WIDTH_LENGTH];
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (bus.out_ready)
            state <= S_RD;
        end
        S_RD: begin
          // cnt stops at len_reg so max LEN never wraps
          if (fire) begin
            if (at_last)
              state <= S_DONE;
            else
              cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt    <= '0;
          rr_ptr <= (q_reg == WIDTH_Q'(NUM_Q-1)) ? '0 : q_reg + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_in_rd_controller_mq.sv
// Directed bench for in_rd_controller_mq.
// Inputs driven on the falling edge; outputs sampled 1ns later.
module tb_in_rd_controller_mq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops;
  int   lasts;

  always #5 clk = ~clk;

  in_rd_controller_mq_if #(
    .NUM_Q(4), .WIDTH_SEL(3), .WIDTH_LENGTH(6), .WIDTH_Q(2)
  ) bus ();

  in_rd_controller_mq #(
    .NUM_Q(4), .WIDTH_SEL(3), .WIDTH_LENGTH(6), .WIDTH_Q(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.req        = '0;
    bus.req_rx     = {3'd6, 3'd5, 3'd4, 3'd3};
    bus.req_len    = '0;
    bus.fifo_empty = '0;
    bus.out_ready  = 1'b1;

    // reset state
    @(negedge clk);
    #1;
    check("rst_busy",  bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_ack",   bus.req_ack, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_q_sel", bus.q_sel, 0);
    check("rst_rx",    bus.rx_out, 0);
    check("rst_last",  bus.out_last, 0);
    rst = 1'b0;
    tick();

    // 1: single request on queue 1, len 3
    bus.req     = 4'b0010;
    bus.req_len = {6'd0, 6'd0, 6'd3, 6'd0};
    #1;
    check("t1_ack",  bus.req_ack, 4'b0010);
    check("t1_busy0", bus.busy, 0);
    tick();
    bus.req = '0;
    #1;
    check("t1_hdr_v",   bus.out_valid, 1);
    check("t1_hdr_sel", bus.out_sel, 1);
    check("t1_q_sel",   bus.q_sel, 1);
    check("t1_rx",      bus.rx_out, 4);
    check("t1_ack_off", bus.req_ack, 0);
    check("t1_hdr_pop", bus.fifo_rd_en, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_beat_v",   bus.out_valid, 1);
      check("t1_beat_sel", bus.out_sel, 0);
      check("t1_pop",      bus.fifo_rd_en, 4'b0010);
      check("t1_last",     bus.out_last, (k == 3));
    end
    tick();
    check("t1_done_busy", bus.busy, 1);
    check("t1_done_v",    bus.out_valid, 0);
    tick();
    check("t1_idle_busy", bus.busy, 0);

    // 2: all queues, len 0, from a fresh pointer
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    bus.req     = 4'b1111;
    bus.req_len = '0;
    for (int f = 0; f < 5; f++) begin
      #1;
      check("t2_ack", bus.req_ack, 32'(1) << (f % 4));
      tick();
      check("t2_q_sel", bus.q_sel, f % 4);
      check("t2_rx",    bus.rx_out, (f % 4) + 3);
      tick();
      check("t2_pop",  bus.fifo_rd_en, 32'(1) << (f % 4));
      check("t2_last", bus.out_last, 1);
      tick();
      check("t2_done_v", bus.out_valid, 0);
      tick();
    end
    bus.req = '0;

    // 3: queue 3, len 5, ready toggling
    bus.req     = 4'b1000;
    bus.req_len = {6'd5, 6'd0, 6'd0, 6'd0};
    #1;
    check("t3_ack", bus.req_ack, 4'b1000);
    tick();
    bus.req       = '0;
    bus.out_ready = 1'b0;
    #1;
    check("t3_hdr_hold", bus.out_sel, 1);
    tick();
    check("t3_hdr_hold2", bus.out_sel, 1);
    check("t3_hdr_v",     bus.out_valid, 1);
    check("t3_hdr_rx",    bus.rx_out, 6);
    bus.out_ready = 1'b1;
    tick();
    pops = 0;
    for (int c = 0; c < 11; c++) begin
      bus.out_ready = (c % 2 == 0);
      #1;
      if (bus.fifo_rd_en != 0) pops++;
      check("t3_pop",   bus.fifo_rd_en, (c % 2 == 0) ? 4'b1000 : 4'b0000);
      check("t3_valid", bus.out_valid, 1);
      check("t3_sel",   bus.out_sel, 0);
      check("t3_rx",    bus.rx_out, 6);
      check("t3_q_sel", bus.q_sel, 3);
      check("t3_last",  bus.out_last, (c >= 9));
      if (c != 10) tick();
    end
    check("t3_pops", pops, 6);
    tick();
    check("t3_done_v", bus.out_valid, 0);
    tick();
    check("t3_idle", bus.busy, 0);

    // 4: queue 0, len 4, FIFO runs dry after two beats
    bus.req     = 4'b0001;
    bus.req_len = {6'd0, 6'd0, 6'd0, 6'd4};
    #1;
    check("t4_ack", bus.req_ack, 4'b0001);
    tick();
    bus.req = '0;
    tick();
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      bus.fifo_empty = (c >= 2 && c < 5) ? 4'b0001 : 4'b0000;
      #1;
      if (bus.fifo_rd_en != 0) pops++;
      check("t4_valid", bus.out_valid, !(c >= 2 && c < 5));
      check("t4_pop",   bus.fifo_rd_en, (c >= 2 && c < 5) ? 4'b0000 : 4'b0001);
      check("t4_last",  bus.out_last, (c == 7));
      tick();
    end
    bus.fifo_empty = '0;
    check("t4_pops", pops, 5);
    check("t4_done_v", bus.out_valid, 0);
    check("t4_done_busy", bus.busy, 1);
    tick();

    // 5: queue 1, max length 63
    bus.req     = 4'b0010;
    bus.req_len = {6'd0, 6'd0, 6'd63, 6'd0};
    #1;
    check("t5_ack", bus.req_ack, 4'b0010);
    tick();
    bus.req = '0;
    tick();
    pops  = 0;
    lasts = 0;
    for (int c = 0; c < 64; c++) begin
      if (bus.fifo_rd_en == 4'b0010) pops++;
      if (bus.out_last) lasts++;
      check("t5_last", bus.out_last, (c == 63));
      tick();
    end
    check("t5_pops",  pops, 64);
    check("t5_lasts", lasts, 1);
    check("t5_done_v", bus.out_valid, 0);
    check("t5_done_busy", bus.busy, 1);
    tick();
    check("t5_idle", bus.busy, 0);

    // 6: reset in the middle of a frame on queue 2
    bus.req     = 4'b0100;
    bus.req_len = {6'd0, 6'd3, 6'd0, 6'd0};
    #1;
    check("t6_ack", bus.req_ack, 4'b0100);
    tick();
    bus.req = '0;
    tick();
    tick();
    check("t6_pre_pop", bus.fifo_rd_en, 4'b0100);
    rst = 1'b1;
    #1;
    check("t6_rst_pop",   bus.fifo_rd_en, 0);
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_busy",  bus.busy, 0);
    #1;
    rst = 1'b0;
    tick();
    bus.req = 4'b1111;
    #1;
    check("t6_regrant", bus.req_ack, 4'b0001);
    tick();
    bus.req = '0;
    #1;
    check("t6_hdr", bus.out_sel, 1);
    check("t6_q_sel", bus.q_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
